// File: rtl/ysyx_22040759_bpu_if.sv
// Bundle of lookup, response, training and redirect signals between the
// ysyx_22040759 pipeline (master) and its branch prediction unit (slave).
interface ysyx_22040759_bpu_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
);
  // IF-side lookup
  logic             q_valid;
  logic [XLEN-1:0]  q_pc;
  logic             flush;
  // registered prediction
  logic             p_valid;
  logic [XLEN-1:0]  p_pc;
  logic             p_taken;
  logic [XLEN-1:0]  p_target;
  // EX-side resolution
  logic             u_valid;
  logic [XLEN-1:0]  u_pc;
  logic             u_is_jump;
  logic             u_taken;
  logic [XLEN-1:0]  u_target;
  logic             u_pred_taken;
  logic [XLEN-1:0]  u_pred_target;
  // registered redirect and statistics
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] miss_cnt;

  modport master (
    output q_valid, q_pc, flush,
    output u_valid, u_pc, u_is_jump, u_taken, u_target, u_pred_taken, u_pred_target,
    input  p_valid, p_pc, p_taken, p_target,
    input  redirect_valid, redirect_pc, br_cnt, miss_cnt
  );

  modport slave (
    input  q_valid, q_pc, flush,
    input  u_valid, u_pc, u_is_jump, u_taken, u_target, u_pred_taken, u_pred_target,
    output p_valid, p_pc, p_taken, p_target,
    output redirect_valid, redirect_pc, br_cnt, miss_cnt
  );
endinterface

// File: rtl/ysyx_22040759_bpu.sv
// Direct-mapped BTB with 2-bit counters: one-cycle registered prediction on
// the IF side, training plus registered mispredict redirect on the EX side,
// and free-running branch/mispredict statistics.
module ysyx_22040759_bpu #(
  parameter int XLEN    = 64,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  ysyx_22040759_bpu_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);

  // table storage, kept in flops
  logic [ENTRIES-1:0] r_valid;
  logic [ENTRIES-1:0] r_jump;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [XLEN-1:0]    r_target [ENTRIES];
  logic [1:0]         r_ctr    [ENTRIES];

  // registered outputs
  logic               r_p_valid;
  logic [XLEN-1:0]    r_p_pc;
  logic               r_p_taken;
  logic [XLEN-1:0]    r_p_target;
  logic               r_redirect_valid;
  logic [XLEN-1:0]    r_redirect_pc;
  logic [CNT_W-1:0]   r_br_cnt;
  logic [CNT_W-1:0]   r_miss_cnt;

  // lookup path (reads the table state before any same-cycle update)
  logic [IDX_W-1:0]   w_q_idx;
  logic [TAG_W-1:0]   w_q_tag;
  logic               w_q_hit;
  logic               w_q_taken;
  logic [XLEN-1:0]    w_q_target;

  assign w_q_idx    = bus.q_pc[IDX_W+1:2];
  assign w_q_tag    = bus.q_pc[XLEN-1:IDX_W+2];
  assign w_q_hit    = r_valid[w_q_idx] & (r_tag[w_q_idx] == w_q_tag);
  assign w_q_taken  = w_q_hit & (r_jump[w_q_idx] | r_ctr[w_q_idx][1]);
  assign w_q_target = w_q_taken ? r_target[w_q_idx] : (bus.q_pc + PC_STEP);

  // update path
  logic [IDX_W-1:0]   w_u_idx;
  logic [TAG_W-1:0]   w_u_tag;
  logic               w_u_hit;
  logic [1:0]         w_ctr_next;
  logic [XLEN-1:0]    w_actual_next;
  logic               w_miss;

  assign w_u_idx       = bus.u_pc[IDX_W+1:2];
  assign w_u_tag       = bus.u_pc[XLEN-1:IDX_W+2];
  assign w_u_hit       = r_valid[w_u_idx] & (r_tag[w_u_idx] == w_u_tag);
  assign w_actual_next = bus.u_taken ? bus.u_target : (bus.u_pc + PC_STEP);
  assign w_miss        = bus.u_valid &
                         ((bus.u_taken != bus.u_pred_taken) |
                          (bus.u_taken & (bus.u_target != bus.u_pred_target)));

  // next counter value: saturating step on a hit, weak seed on a replacement
  always_comb begin
    w_ctr_next = r_ctr[w_u_idx];
    if (!w_u_hit) begin
      w_ctr_next = bus.u_taken ? 2'b10 : 2'b01;
    end else if (bus.u_taken) begin
      w_ctr_next = (r_ctr[w_u_idx] == 2'b11) ? 2'b11 : (r_ctr[w_u_idx] + 2'b01);
    end else begin
      w_ctr_next = (r_ctr[w_u_idx] == 2'b00) ? 2'b00 : (r_ctr[w_u_idx] - 2'b01);
    end
  end

  // table write: reset invalidates everything, a resolved branch trains its entry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_ctr[i] <= 2'b01;
      end
    end else if (bus.u_valid) begin
      r_valid[w_u_idx]  <= 1'b1;
      r_jump[w_u_idx]   <= bus.u_is_jump;
      r_tag[w_u_idx]    <= w_u_tag;
      r_target[w_u_idx] <= bus.u_target;
      r_ctr[w_u_idx]    <= w_ctr_next;
    end
  end

  // prediction register: flush only kills the valid bit, other fields follow q_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p_valid  <= 1'b0;
      r_p_pc     <= '0;
      r_p_taken  <= 1'b0;
      r_p_target <= '0;
    end else begin
      r_p_valid <= bus.q_valid & ~bus.flush;
      if (bus.q_valid) begin
        r_p_pc     <= bus.q_pc;
        r_p_taken  <= w_q_taken;
        r_p_target <= w_q_target;
      end
    end
  end

  // redirect register: one-cycle pulse per mispredict, PC holds otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_redirect_valid <= w_miss;
      if (w_miss) begin
        r_redirect_pc <= w_actual_next;
      end
    end
  end

  // wrapping statistics counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_br_cnt   <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (bus.u_valid) begin
        r_br_cnt <= r_br_cnt + CNT_W'(1'b1);
      end
      if (w_miss) begin
        r_miss_cnt <= r_miss_cnt + CNT_W'(1'b1);
      end
    end
  end

  assign bus.p_valid        = r_p_valid;
  assign bus.p_pc           = r_p_pc;
  assign bus.p_taken        = r_p_taken;
  assign bus.p_target       = r_p_target;
  assign bus.redirect_valid = r_redirect_valid;
  assign bus.redirect_pc    = r_redirect_pc;
  assign bus.br_cnt         = r_br_cnt;
  assign bus.miss_cnt       = r_miss_cnt;
endmodule

// File: tb/tb_ysyx_22040759_bpu.sv
// Directed bench for ysyx_22040759_bpu: a table-of-entries reference model
// predicts every output each cycle, and literal checks pin key scenarios.
module tb_ysyx_22040759_bpu;
  localparam int XLEN    = 64;
  localparam int ENTRIES = 16;
  localparam int CNT_W   = 32;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  ysyx_22040759_bpu_if #(.XLEN(XLEN), .CNT_W(CNT_W)) u_if ();

  ysyx_22040759_bpu #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CNT_W(CNT_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: one record per BTB slot
  logic        m_valid  [ENTRIES];
  logic [63:0] m_tag    [ENTRIES];
  logic [63:0] m_target [ENTRIES];
  logic        m_jump   [ENTRIES];
  int          m_ctr    [ENTRIES];

  // expected outputs visible after the current edge
  logic        e_p_valid, e_p_taken, e_rd_valid;
  logic [63:0] e_p_pc, e_p_target, e_rd_pc;
  longint      e_br, e_miss;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("p_valid", {63'd0, u_if.p_valid}, {63'd0, e_p_valid});
    if (e_p_valid) begin
      chk("p_pc", u_if.p_pc, e_p_pc);
      chk("p_taken", {63'd0, u_if.p_taken}, {63'd0, e_p_taken});
      chk("p_target", u_if.p_target, e_p_target);
    end
    chk("redirect_valid", {63'd0, u_if.redirect_valid}, {63'd0, e_rd_valid});
    chk("redirect_pc", u_if.redirect_pc, e_rd_pc);
    chk("br_cnt", {32'd0, u_if.br_cnt}, e_br[63:0] & 64'hFFFF_FFFF);
    chk("miss_cnt", {32'd0, u_if.miss_cnt}, e_miss[63:0] & 64'hFFFF_FFFF);
  endtask

  // one clock: predict from pre-edge state, advance the model, compare on negedge
  task automatic tick();
    logic        n_p_valid, n_p_taken, n_rd_valid, hit, tk, miss, do_upd;
    logic [63:0] n_p_pc, n_p_target, n_rd_pc, actual;
    longint      n_br, n_miss;
    int          qi, ui;
    n_p_valid = e_p_valid; n_p_taken = e_p_taken; n_p_pc = e_p_pc; n_p_target = e_p_target;
    n_rd_valid = e_rd_valid; n_rd_pc = e_rd_pc; n_br = e_br; n_miss = e_miss;
    do_upd = 1'b0;
    ui = int'((u_if.u_pc / 4) % ENTRIES);
    if (rst) begin
      n_p_valid = 1'b0; n_p_taken = 1'b0; n_p_pc = 64'd0; n_p_target = 64'd0;
      n_rd_valid = 1'b0; n_rd_pc = 64'd0; n_br = 0; n_miss = 0;
    end else begin
      n_p_valid = u_if.q_valid & ~u_if.flush;
      if (u_if.q_valid) begin
        qi  = int'((u_if.q_pc / 4) % ENTRIES);
        hit = m_valid[qi] && (m_tag[qi] == u_if.q_pc / (4 * ENTRIES));
        tk  = hit && (m_jump[qi] || m_ctr[qi] >= 2);
        n_p_pc     = u_if.q_pc;
        n_p_taken  = tk;
        n_p_target = tk ? m_target[qi] : u_if.q_pc + 64'd4;
      end
      n_rd_valid = 1'b0;
      if (u_if.u_valid) begin
        do_upd = 1'b1;
        n_br++;
        actual = u_if.u_taken ? u_if.u_target : u_if.u_pc + 64'd4;
        miss = (u_if.u_taken != u_if.u_pred_taken) ||
               (u_if.u_taken && (u_if.u_target != u_if.u_pred_target));
        if (miss) begin
          n_miss++;
          n_rd_valid = 1'b1;
          n_rd_pc    = actual;
        end
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] = 1'b0;
        m_ctr[i]   = 1;
      end
    end else if (do_upd) begin
      hit = m_valid[ui] && (m_tag[ui] == u_if.u_pc / (4 * ENTRIES));
      if (!hit) m_ctr[ui] = u_if.u_taken ? 2 : 1;
      else if (u_if.u_taken) m_ctr[ui] = (m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3;
      else m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
      m_valid[ui]  = 1'b1;
      m_tag[ui]    = u_if.u_pc / (4 * ENTRIES);
      m_target[ui] = u_if.u_target;
      m_jump[ui]   = u_if.u_is_jump;
    end
    e_p_valid = n_p_valid; e_p_taken = n_p_taken; e_p_pc = n_p_pc; e_p_target = n_p_target;
    e_rd_valid = n_rd_valid; e_rd_pc = n_rd_pc; e_br = n_br; e_miss = n_miss;
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    u_if.q_valid = 1'b0; u_if.q_pc = 64'd0; u_if.flush = 1'b0;
    u_if.u_valid = 1'b0; u_if.u_pc = 64'd0; u_if.u_is_jump = 1'b0; u_if.u_taken = 1'b0;
    u_if.u_target = 64'd0; u_if.u_pred_taken = 1'b0; u_if.u_pred_target = 64'd0;
  endtask

  task automatic look(input logic [63:0] pc);
    u_if.q_valid = 1'b1; u_if.q_pc = pc;
  endtask

  task automatic upd(input logic [63:0] pc, input logic jmp, input logic tk,
                     input logic [63:0] tgt, input logic ptk, input logic [63:0] ptgt);
    u_if.u_valid = 1'b1; u_if.u_pc = pc; u_if.u_is_jump = jmp; u_if.u_taken = tk;
    u_if.u_target = tgt; u_if.u_pred_taken = ptk; u_if.u_pred_target = ptgt;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    e_p_valid = 1'b0; e_p_taken = 1'b0; e_p_pc = 64'd0; e_p_target = 64'd0;
    e_rd_valid = 1'b0; e_rd_pc = 64'd0; e_br = 0; e_miss = 0;
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 64'd0; m_target[i] = 64'd0; m_jump[i] = 1'b0; m_ctr[i] = 1;
    end
    idle();
    rst = 1'b1;
    tick(); tick();
    chk("rst_p_valid", {63'd0, u_if.p_valid}, 64'd0);
    chk("rst_br_cnt", {32'd0, u_if.br_cnt}, 64'd0);
    chk("rst_redirect_pc", u_if.redirect_pc, 64'd0);
    rst = 1'b0;

    // cold lookup falls through
    look(64'h8000_0000); tick(); idle();
    chk("cold_p_valid", {63'd0, u_if.p_valid}, 64'd1);
    chk("cold_p_taken", {63'd0, u_if.p_taken}, 64'd0);
    chk("cold_p_target", u_if.p_target, 64'h8000_0004);

    // first taken B-type mispredicts and installs ctr=10
    upd(64'h8000_0010, 1'b0, 1'b1, 64'h8000_0100, 1'b0, 64'h8000_0014); tick(); idle();
    chk("mp_redirect_valid", {63'd0, u_if.redirect_valid}, 64'd1);
    chk("mp_redirect_pc", u_if.redirect_pc, 64'h8000_0100);
    chk("mp_br_cnt", {32'd0, u_if.br_cnt}, 64'd1);
    chk("mp_miss_cnt", {32'd0, u_if.miss_cnt}, 64'd1);
    look(64'h8000_0010); tick(); idle();
    chk("train_p_taken", {63'd0, u_if.p_taken}, 64'd1);
    chk("train_p_target", u_if.p_target, 64'h8000_0100);
    chk("pulse_ends", {63'd0, u_if.redirect_valid}, 64'd0);

    // saturation: 10 -> 11 x3, then not taken -> 10 (still taken)
    for (int i = 0; i < 3; i++) begin
      upd(64'h8000_0010, 1'b0, 1'b1, 64'h8000_0100, 1'b1, 64'h8000_0100); tick(); idle();
    end
    upd(64'h8000_0010, 1'b0, 1'b0, 64'h8000_0100, 1'b1, 64'h8000_0100); tick(); idle();
    look(64'h8000_0010); tick(); idle();
    chk("sat_hi_taken", {63'd0, u_if.p_taken}, 64'd1);
    for (int i = 0; i < 2; i++) begin
      upd(64'h8000_0010, 1'b0, 1'b0, 64'h8000_0100, 1'b0, 64'h8000_0014); tick(); idle();
    end
    look(64'h8000_0010); tick(); idle();
    chk("sat_lo_taken", {63'd0, u_if.p_taken}, 64'd0);
    chk("sat_lo_target", u_if.p_target, 64'h8000_0014);

    // JAL always predicted taken; JALR target mismatch redirects
    upd(64'h8000_0020, 1'b1, 1'b1, 64'h8000_0400, 1'b0, 64'h8000_0024); tick(); idle();
    for (int i = 0; i < 4; i++) begin
      look(64'h8000_0020); tick(); idle();
      chk("jal_taken", {63'd0, u_if.p_taken}, 64'd1);
      chk("jal_target", u_if.p_target, 64'h8000_0400);
    end
    upd(64'h8000_0030, 1'b1, 1'b1, 64'h8000_0200, 1'b1, 64'h8000_0300); tick(); idle();
    chk("jalr_redirect_pc", u_if.redirect_pc, 64'h8000_0200);
    chk("jalr_miss_cnt", {32'd0, u_if.miss_cnt}, 64'd4);
    chk("jalr_br_cnt", {32'd0, u_if.br_cnt}, 64'd9);

    // alias hazard: same-cycle update of an aliasing PC does not affect the lookup
    for (int i = 0; i < 2; i++) begin
      upd(64'h8000_0010, 1'b0, 1'b1, 64'h8000_0100, 1'b1, 64'h8000_0100); tick(); idle();
    end
    upd(64'h8000_0050, 1'b0, 1'b1, 64'h8000_0600, 1'b1, 64'h8000_0600);
    look(64'h8000_0010); tick(); idle();
    chk("alias_old_taken", {63'd0, u_if.p_taken}, 64'd1);
    chk("alias_old_target", u_if.p_target, 64'h8000_0100);
    look(64'h8000_0010); tick(); idle();
    chk("alias_new_taken", {63'd0, u_if.p_taken}, 64'd0);
    chk("alias_new_target", u_if.p_target, 64'h8000_0014);

    // flush kills the same-cycle lookup
    look(64'h8000_0020); u_if.flush = 1'b1; tick(); idle();
    chk("flush_p_valid", {63'd0, u_if.p_valid}, 64'd0);

    // reset right after a mispredict drops the pulse and clears everything
    upd(64'h8000_0040, 1'b0, 1'b1, 64'h8000_0800, 1'b0, 64'h8000_0044); tick(); idle();
    chk("pre_rst_redirect", {63'd0, u_if.redirect_valid}, 64'd1);
    rst = 1'b1;
    look(64'h8000_0020);
    upd(64'h8000_0040, 1'b0, 1'b1, 64'h8000_0900, 1'b0, 64'h8000_0044);
    tick(); idle(); rst = 1'b0;
    chk("rst_redirect_valid", {63'd0, u_if.redirect_valid}, 64'd0);
    chk("rst_miss_cnt", {32'd0, u_if.miss_cnt}, 64'd0);
    chk("rst_br_cnt2", {32'd0, u_if.br_cnt}, 64'd0);
    look(64'h8000_0020); tick(); idle();
    chk("post_rst_taken", {63'd0, u_if.p_taken}, 64'd0);

    // fall-through target wraps modulo 2^64
    look(64'hFFFF_FFFF_FFFF_FFFC); tick(); idle();
    chk("wrap_target", u_if.p_target, 64'd0);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
